// File: rtl/apb_rah_pkg.sv
// Shared definitions for the APB RAH frame format, used by the encoder and decoder.
// Field positions describe the default 48-bit frame with 7-bit slave id and length.
package apb_rah_pkg;

   // Byte budgets of the frame format
   localparam int HDR_BYTES   = 4;   // payload bytes carried in the header frame
   localparam int FRAME_BYTES = 6;   // payload bytes carried in a continuation frame
   localparam int WORD_BYTES  = 4;   // bytes per payload word
   localparam int ACC_BYTES   = 9;   // packer depth: five leftover bytes plus one word

   // Header field bit positions
   localparam int HDR_CFG_BIT = 47;
   localparam int HDR_SLV_MSB = 46;
   localparam int HDR_SLV_LSB = 40;
   localparam int HDR_RW_BIT  = 39;
   localparam int HDR_LEN_MSB = 38;
   localparam int HDR_LEN_LSB = 32;
   localparam int HDR_PAY_MSB = 31;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/apb_enc_packer.sv
// Byte accumulator for the APB RAH encoder: appends the valid bytes of each payload
// word, releases header (4 byte) or continuation (6 byte) chunks from the front, and
// tracks how many payload bytes of the current packet are still to be accepted.
module apb_enc_packer
   import apb_rah_pkg::*;
#(
   parameter int LENGTH_WIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [LENGTH_WIDTH-1:0]  load_length,
   input  logic                     push,
   input  logic [31:0]              push_data,
   input  logic                     pop,
   input  logic                     pop_hdr,
   output logic [3:0]               count,
   output logic                     words_left,
   output logic [FRAME_BYTES*8-1:0] frame
);

   logic [7:0]              acc_q [ACC_BYTES];
   logic [7:0]              acc_d [ACC_BYTES];
   logic [3:0]              count_q;
   logic [3:0]              count_d;
   logic [3:0]              rem;
   logic [3:0]              take;
   logic [LENGTH_WIDTH-1:0] left_q;
   logic [LENGTH_WIDTH-1:0] left_d;

   // Drop the popped chunk from the front, then append the accepted bytes behind what remains
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      take   = (left_q >= LENGTH_WIDTH'(WORD_BYTES)) ? 4'(WORD_BYTES) : 4'(left_q);
      left_d = push ? left_q - LENGTH_WIDTH'(take) : left_q;
      rem    = count_q;
      acc_d  = acc_q;
      if (pop) begin
         for (int i = 0; i < ACC_BYTES; i++) acc_d[i] = 8'h00;
         if (pop_hdr) begin
            rem = (count_q > 4'(HDR_BYTES)) ? count_q - 4'(HDR_BYTES) : 4'd0;
            for (int i = 0; i < ACC_BYTES - HDR_BYTES; i++) acc_d[i] = acc_q[i + HDR_BYTES];
         end else begin
            rem = (count_q > 4'(FRAME_BYTES)) ? count_q - 4'(FRAME_BYTES) : 4'd0;
            for (int i = 0; i < ACC_BYTES - FRAME_BYTES; i++) acc_d[i] = acc_q[i + FRAME_BYTES];
         end
      end
      // Bytes past the packet length are never written, so trailing bytes stay zero
      if (push) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            for (int j = 0; j < ACC_BYTES; j++) begin
               if (k < int'(take) && j == int'(rem) + k) acc_d[j] = push_data[31-8*k -: 8];
            end
         end
      end
      count_d = rem + (push ? take : 4'd0);
   end

   // Accumulator, byte count and remaining-length registers
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the accumulator is nine bytes of plain flops, so it is reset with the rest of the state.
      if (!rst_n) begin
         for (int i = 0; i < ACC_BYTES; i++) acc_q[i] <= 8'h00;
         count_q <= 4'd0;
         left_q  <= '0;
      end else if (load) begin
         for (int i = 0; i < ACC_BYTES; i++) acc_q[i] <= 8'h00;
         count_q <= 4'd0;
         left_q  <= load_length;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         acc_q   <= acc_d;
         count_q <= count_d;
         left_q  <= left_d;
      end
   end

   // The front six bytes form the next frame payload, first byte in the top bits
   always_comb begin
      frame = '0;
      for (int i = 0; i < FRAME_BYTES; i++) frame[8*(FRAME_BYTES-1-i) +: 8] = acc_q[i];
   end

   assign count      = count_q;
   assign words_left = (left_q != '0);

endmodule

// File: rtl/apb_encoder.sv
// APB RAH encoder: takes a packet command plus a stream of 32-bit payload words and
// writes 48-bit frames (one header frame, then 6-byte continuation frames) to a FIFO.
module apb_encoder
   import apb_rah_pkg::*;
#(
   parameter int LENGTH_WIDTH     = 7,
   parameter int SLV_ID_WIDTH     = 7,
   parameter int RAH_PACKET_WIDTH = 48
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_cfg_sel,
   input  logic [SLV_ID_WIDTH-1:0]     cmd_slv_id,
   input  logic                        cmd_rw,
   input  logic [LENGTH_WIDTH-1:0]     cmd_length,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [31:0]                 s_data,
   input  logic                        f_full,
   output logic                        wr_en,
   output logic [RAH_PACKET_WIDTH-1:0] wr_data
);

   logic [1:0]                  state_q;
   logic [1:0]                  state_d;
   logic                        cfg_q;
   logic                        rw_q;
   logic [SLV_ID_WIDTH-1:0]     slv_q;
   logic [LENGTH_WIDTH-1:0]     len_q;
   logic [3:0]                  count;
   logic                        words_left;
   logic [FRAME_BYTES*8-1:0]    frame;
   logic                        cmd_hs;
   logic                        push;
   logic                        hdr_buffered;
   logic                        hdr_write;
   logic                        data_write;
   logic                        last_write;
   logic [RAH_PACKET_WIDTH-1:0] hdr_frame;

   apb_enc_packer #(.LENGTH_WIDTH(LENGTH_WIDTH)) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (cmd_hs),
      .load_length (cmd_length),
      .push        (push),
      .push_data   (s_data),
      .pop         (hdr_write || data_write),
      .pop_hdr     (hdr_write),
      .count       (count),
      .words_left  (words_left),
      .frame       (frame)
   );

   // Handshakes and frame-write decisions, all derived from registered state
   always_comb begin
      cmd_ready    = (state_q == ST_IDLE);
      cmd_hs       = cmd_valid && cmd_ready;
      // Header bytes are complete once four are held or the whole (short) payload is in
      hdr_buffered = (state_q == ST_HDR) && ((count >= 4'(HDR_BYTES)) || !words_left);
      s_ready      = ((state_q == ST_HDR) || (state_q == ST_DATA)) && words_left &&
                     (count <= 4'(FRAME_BYTES - 1)) && !hdr_buffered;
      push         = s_valid && s_ready;
      hdr_write    = hdr_buffered && !f_full;
      data_write   = (state_q == ST_DATA) && !f_full &&
                     ((count >= 4'(FRAME_BYTES)) || (!words_left && (count != 4'd0)));
      last_write   = data_write && !words_left && (count <= 4'(FRAME_BYTES));
   end

   // Packet sequencing: wait for a command, emit the header, then continuation frames
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_hs) state_d = ST_HDR;
         ST_HDR:  if (hdr_write) state_d = (len_q > LENGTH_WIDTH'(HDR_BYTES)) ? ST_DATA : ST_IDLE;
         ST_DATA: if (last_write) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Header frame from the registered command fields and the first four payload bytes
   always_comb begin
      hdr_frame                          = '0;
      hdr_frame[HDR_CFG_BIT]             = cfg_q;
      hdr_frame[HDR_SLV_MSB:HDR_SLV_LSB] = slv_q;
      hdr_frame[HDR_RW_BIT]              = rw_q;
      hdr_frame[HDR_LEN_MSB:HDR_LEN_LSB] = len_q;
      hdr_frame[HDR_PAY_MSB:0]           = frame[FRAME_BYTES*8-1 -: HDR_BYTES*8];
   end

   // State and command registers; command fields are captured at the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cfg_q   <= 1'b0;
         rw_q    <= 1'b0;
         slv_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         if (cmd_hs) begin
            cfg_q <= cmd_cfg_sel;
            rw_q  <= cmd_rw;
            slv_q <= cmd_slv_id;
            len_q <= cmd_length;
         end
      end
   end

   // Registered FIFO write port; data is forced to zero whenever no frame is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_data <= '0;
      end else begin
         wr_en <= hdr_write || data_write;
         if (hdr_write)       wr_data <= hdr_frame;
         else if (data_write) wr_data <= RAH_PACKET_WIDTH'(frame);
         else                 wr_data <= '0;
      end
   end

endmodule

// File: doc/apb_encoder.md
APB_ENCODER -- requirements
Module: apb_encoder

Interface
REQ-001 SHALL have parameter LENGTH_WIDTH, default 7, payload byte-count width.
REQ-002 SHALL have parameter SLV_ID_WIDTH, default 7, slave-id width.
REQ-003 SHALL have parameter RAH_PACKET_WIDTH, default 48, frame width; field positions are defined for the defaults only.
REQ-004 SHALL have the following ports (clock and reset first):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  packet command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_cfg_sel  in  1  header config-select bit.
- cmd_slv_id  in  SLV_ID_WIDTH  responding slave id.
- cmd_rw  in  1  read/write flag carried in the header.
- cmd_length  in  LENGTH_WIDTH  payload bytes, 0..127.
- s_valid  in  1  payload word present.
- s_ready  out  1  payload word accepted when high together with s_valid.
- s_data  in  32  payload word; byte0 in [31:24].
- f_full  in  1  output FIFO full.
- wr_en  out  1  FIFO write strobe, one cycle per frame.
- wr_data  out  RAH_PACKET_WIDTH  frame written.

Function
REQ-005 SHALL lay out the header frame as [47] cfg_sel, [46:40] slv_id, [39] rw, [38:32] length, [31:0] payload bytes 0..3, MSB first.
REQ-006 SHALL carry payload bytes 4.. in continuation frames at 6 bytes per frame, MSB first.
REQ-007 SHALL zero-fill unused trailing bytes of the last frame.
REQ-008 SHALL emit 1 + ceil(max(length-4,0)/6) frames per packet; length 127 gives 22 frames.
REQ-009 SHALL consume exactly ceil(length/4) payload words per packet and SHALL discard bytes beyond length in the last word.
REQ-010 SHALL implement the FSM states IDLE, HDR, DATA, with these transitions:
- IDLE->HDR on command handshake.
- HDR->DATA once the header has been written and length > 4.
- HDR->IDLE once the header has been written and length <= 4.
- DATA->IDLE once the last frame has been written.
REQ-011 SHALL assert cmd_ready only in IDLE and SHALL register all command fields at the handshake.
REQ-012 SHALL, for length 0, write the header without consuming any word.
REQ-013 SHALL, for length > 0, write the header the cycle after the first word handshake, provided f_full is low.
REQ-014 SHALL hold buffered bytes in a 9-byte accumulator with a 0..9 count.
REQ-015 SHALL assert s_ready only when all of the following hold: state is HDR or DATA, words remain, the accumulator count is <= 5, and the header is not already buffered-but-unwritten.
REQ-016 SHALL write a continuation frame when f_full is low and either the accumulator count is >= 6, or no words remain and the count is > 0.
REQ-017 SHALL allow a word accept and a frame write in the same cycle: next count = count - 6 (or 0 for the final frame) + bytes accepted.
REQ-018 SHALL register wr_data and wr_en and SHALL drive wr_en high for exactly one cycle per frame.
REQ-019 SHALL never assert wr_en in a cycle where f_full was sampled high; while stalled, the frame is held and no data is lost or duplicated.
REQ-020 SHALL return cmd_ready high the cycle after the last frame is written, so back-to-back packets have no extra idle cycle.
REQ-021 SHALL drive wr_data to 0 when wr_en is low.

Reset
REQ-022 SHALL, while rst_n is low, clear the FSM to IDLE, clear the accumulator and counters, drive wr_en, wr_data and s_ready to 0, and drive cmd_ready to 1 after release.
REQ-023 SHALL, on reset mid-packet, discard the partial packet; no further frames of that packet are written.

Structure
REQ-024 SHALL place the header field bit positions, HDR_BYTES = 4, FRAME_BYTES = 6 and the FSM state encoding in shared package apb_rah_pkg, which is also used by apb_decoder.
REQ-025 SHALL put the accumulator and byte-count logic in sub-module apb_enc_packer; the FSM and handshakes stay in apb_encoder.

Verification
REQ-026 SHALL cover: slv_id=5, rw=1, cfg=0, length=0 -> one frame 48'h0580_0000_0000, s_ready never high.
REQ-027 SHALL cover: length=4, word 32'hDEADBEEF -> one frame 48'h0584_DEADBEEF.
REQ-028 SHALL cover: length=10, words 11223344/55667788/99AABBCC -> frames 48'h058A_11223344 then 48'h5566_778899AA.
REQ-029 SHALL cover: length=13, words 00010203/04050607/08090A0B/0C000000 -> frames 48'h058D_00010203, 48'h0405_06070809, 48'h0A0B_0C000000.
REQ-030 SHALL cover: REQ-028 stimulus with f_full high 5 cycles mid-packet -> no wr_en while full, identical frames after release.
REQ-031 SHALL cover: rst_n pulsed low after the header of a length-13 packet -> outputs 0, then a fresh length-4 packet yields exactly one correct frame.
